clock_time_counter: RTL and testbench

Parametrised time-of-day counter for the clock design. Divides the system clock into a 1 Hz tick and keeps seconds, minutes and hours as BCD. Supports run/pause, runtime 12/24-hour display and field-wise time setting with range checking. Sits between the board clock and the display/alarm logic and generalises the fixed 8-bit seconds counter.

---
 rtl/clock_time_counter_pkg.sv | 45 ++++
 rtl/clock_time_counter_bcd_mod_counter.sv | 48 ++++
 rtl/clock_time_counter.sv | 163 ++++++++++++++++
 tb/tb_clock_time_counter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_time_counter_pkg.sv
// Shared field encodings, BCD limits and BCD helper functions for the
// time-of-day counter.
package clock_pkg;

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  localparam logic [7:0] BCD_MAX_SEC_MIN = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR    = 8'h23;
  localparam logic [7:0] BCD_NOON        = 8'h12;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Only used on hour values, so five bits cover 0..23.
  function automatic logic [4:0] bcd_to_bin(input logic [7:0] v);
    return 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [4:0] b);
    logic [7:0] r;
    if (b >= 5'd20) begin
      r = {4'd2, 4'(b - 5'd20)};
    end else if (b >= 5'd10) begin
      r = {4'd1, 4'(b - 5'd10)};
    end else begin
      r = {4'd0, b[3:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_time_counter_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX; load wins over increment and
// suppresses the carry out.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_MAX_SEC_MIN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_r;
  logic [7:0] next_s;

  assign value = value_r;
  assign carry = inc & ~load & (value_r == MAX);

  // next-value selection: load, wrap, BCD increment or hold
  always_comb begin
    next_s = value_r;
    if (load) begin
      next_s = load_val;
    end else if (inc) begin
      if (value_r == MAX) begin
        next_s = 8'h00;
      end else begin
        next_s = bcd_inc(value_r);
      end
    end else begin
      next_s = value_r;
    end
  end

  // field state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= 8'h00;
    end else begin
      value_r <= next_s;
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// Time-of-day counter: prescaler to a 1 Hz tick, BCD sec/min/hour chain,
// range-checked field loading and 12/24-hour display decode.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       run_in,
  input  logic       mode24_in,
  input  logic       set_en_in,
  input  logic [1:0] set_sel_in,
  input  logic [7:0] set_val_in,
  output logic [7:0] sec_out,
  output logic [7:0] min_out,
  output logic [7:0] hour_out,
  output logic       pm_out,
  output logic       tick_out,
  output logic       rollover_out,
  output logic       err_out
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic          set_ok_s;
  logic          err_s;
  logic [7:0]    limit_s;
  logic          load_sec_s;
  logic          load_min_s;
  logic          load_hour_s;
  logic          sec_carry_s;
  logic          min_carry_s;
  logic          hour_carry_s;
  logic [7:0]    sec_r;
  logic [7:0]    min_r;
  logic [7:0]    hour_r;
  logic          tick_r;
  logic          rollover_r;
  logic          err_r;
  logic [7:0]    hour_disp_s;
  logic          pm_s;

  assign tick_s = run_in && (presc_r == PRESC_LAST);

  // set request validation and field-load decode
  always_comb begin
    limit_s     = BCD_MAX_SEC_MIN;
    load_sec_s  = 1'b0;
    load_min_s  = 1'b0;
    load_hour_s = 1'b0;
    if (set_sel_in == SEL_HOUR) begin
      limit_s = BCD_MAX_HOUR;
    end else begin
      limit_s = BCD_MAX_SEC_MIN;
    end
    set_ok_s = set_en_in && (set_sel_in != SEL_RSVD) &&
               bcd_valid(set_val_in) && (set_val_in <= limit_s);
    err_s    = set_en_in && !set_ok_s;
    case (set_sel_in)
      SEL_SEC:  load_sec_s  = set_ok_s;
      SEL_MIN:  load_min_s  = set_ok_s;
      SEL_HOUR: load_hour_s = set_ok_s;
      default: begin
        load_sec_s  = 1'b0;
        load_min_s  = 1'b0;
        load_hour_s = 1'b0;
      end
    endcase
  end

  // prescaler; loading seconds restarts the full tick interval
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      presc_r <= '0;
    end else if (load_sec_s) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else if (run_in) begin
      presc_r <= presc_r + PW'(1'b1);
    end else begin
      presc_r <= presc_r;
    end
  end

  bcd_mod_counter #(.MAX(BCD_MAX_SEC_MIN)) u_sec (
    .clk      (clk_in),
    .rst_n    (reset_in),
    .inc      (tick_s),
    .load     (load_sec_s),
    .load_val (set_val_in),
    .value    (sec_r),
    .carry    (sec_carry_s)
  );

  bcd_mod_counter #(.MAX(BCD_MAX_SEC_MIN)) u_min (
    .clk      (clk_in),
    .rst_n    (reset_in),
    .inc      (sec_carry_s),
    .load     (load_min_s),
    .load_val (set_val_in),
    .value    (min_r),
    .carry    (min_carry_s)
  );

  bcd_mod_counter #(.MAX(BCD_MAX_HOUR)) u_hour (
    .clk      (clk_in),
    .rst_n    (reset_in),
    .inc      (min_carry_s),
    .load     (load_hour_s),
    .load_val (set_val_in),
    .value    (hour_r),
    .carry    (hour_carry_s)
  );

  // status pulses aligned with the cycle the new time becomes visible
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      tick_r     <= 1'b0;
      rollover_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      tick_r     <= tick_s;
      rollover_r <= hour_carry_s;
      err_r      <= err_s;
    end
  end

  // 12-hour view of the 24-hour internal hour; state is never touched
  always_comb begin
    hour_disp_s = hour_r;
    pm_s        = 1'b0;
    if (mode24_in) begin
      hour_disp_s = hour_r;
      pm_s        = 1'b0;
    end else if (hour_r == 8'h00) begin
      hour_disp_s = BCD_NOON;
      pm_s        = 1'b0;
    end else if (hour_r < BCD_NOON) begin
      hour_disp_s = hour_r;
      pm_s        = 1'b0;
    end else if (hour_r == BCD_NOON) begin
      hour_disp_s = BCD_NOON;
      pm_s        = 1'b1;
    end else begin
      hour_disp_s = bin_to_bcd(bcd_to_bin(hour_r) - 5'd12);
      pm_s        = 1'b1;
    end
  end

  assign sec_out      = sec_r;
  assign min_out      = min_r;
  assign hour_out     = hour_disp_s;
  assign pm_out       = pm_s;
  assign tick_out     = tick_r;
  assign rollover_out = rollover_r;
  assign err_out      = err_r;

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench: directed scenarios then random traffic, all checked
// against an integer time-of-day model.
module tb_clock_time_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       run_in;
  logic       mode24_in;
  logic       set_en_in;
  logic [1:0] set_sel_in;
  logic [7:0] set_val_in;
  logic [7:0] sec_out;
  logic [7:0] min_out;
  logic [7:0] hour_out;
  logic       pm_out;
  logic       tick_out;
  logic       rollover_out;
  logic       err_out;

  int total = 0;
  int bad   = 0;

  int m_sec, m_min, m_hour, m_cnt;
  bit m_tick, m_roll, m_err;

  clock_time_counter #(.TICK_DIV(TD)) dut (
    .clk_in       (clk),
    .reset_in     (reset_in),
    .run_in       (run_in),
    .mode24_in    (mode24_in),
    .set_en_in    (set_en_in),
    .set_sel_in   (set_sel_in),
    .set_val_in   (set_val_in),
    .sec_out      (sec_out),
    .min_out      (min_out),
    .hour_out     (hour_out),
    .pm_out       (pm_out),
    .tick_out     (tick_out),
    .rollover_out (rollover_out),
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int x);
    return 8'(((x / 10) * 16) + (x % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_cnt = 0;
    m_tick = 1'b0; m_roll = 1'b0; m_err = 1'b0;
  endtask

  // Model of one clock edge, using the inputs currently applied.
  task automatic model_edge();
    bit tick, vset, c_s, c_m;
    int vt, vu, vbin, lim, t;
    tick = run_in && (m_cnt == TD - 1);
    vt   = int'(set_val_in[7:4]);
    vu   = int'(set_val_in[3:0]);
    vbin = vt * 10 + vu;
    lim  = (set_sel_in == 2'd2) ? 23 : 59;
    vset = set_en_in && (set_sel_in != 2'd3) && vt <= 9 && vu <= 9 && vbin <= lim;
    m_err  = set_en_in && !vset;
    m_tick = tick;
    m_roll = 1'b0;
    if (vset && set_sel_in == 2'd0) m_cnt = 0;
    else if (run_in) m_cnt = (m_cnt + 1) % TD;
    if (!vset) begin
      if (tick) begin
        t = m_hour * 3600 + m_min * 60 + m_sec;
        m_roll = (t == 86399);
        t = (t + 1) % 86400;
        m_hour = t / 3600; m_min = (t / 60) % 60; m_sec = t % 60;
      end
    end else begin
      c_s = tick && m_sec == 59 && set_sel_in != 2'd0;
      if (set_sel_in == 2'd0) m_sec = vbin;
      else if (tick) m_sec = (m_sec + 1) % 60;
      c_m = c_s && m_min == 59 && set_sel_in != 2'd1;
      if (set_sel_in == 2'd1) m_min = vbin;
      else if (c_s) m_min = (m_min + 1) % 60;
      if (set_sel_in == 2'd2) m_hour = vbin;
      else if (c_m) m_hour = (m_hour + 1) % 24;
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eh;
    logic       ep;
    if (mode24_in) begin
      eh = to_bcd(m_hour); ep = 1'b0;
    end else begin
      eh = to_bcd((m_hour % 12 == 0) ? 12 : m_hour % 12);
      ep = (m_hour >= 12);
    end
    chk({tag, ".sec"},  sec_out,  to_bcd(m_sec));
    chk({tag, ".min"},  min_out,  to_bcd(m_min));
    chk({tag, ".hour"}, hour_out, eh);
    chk({tag, ".pm"},   {7'd0, pm_out},       {7'd0, ep});
    chk({tag, ".tick"}, {7'd0, tick_out},     {7'd0, m_tick});
    chk({tag, ".roll"}, {7'd0, rollover_out}, {7'd0, m_roll});
    chk({tag, ".err"},  {7'd0, err_out},      {7'd0, m_err});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_set(input logic [1:0] sel, input logic [7:0] val, input string tag);
    set_en_in  = 1'b1;
    set_sel_in = sel;
    set_val_in = val;
    step(tag);
    set_en_in  = 1'b0;
  endtask

  initial begin
    reset_in = 1'b0; run_in = 1'b0; mode24_in = 1'b1;
    set_en_in = 1'b0; set_sel_in = 2'd0; set_val_in = 8'h00;
    model_reset();
    #2;
    check_all("reset24");
    mode24_in = 1'b0;
    #1;
    chk("reset12.hour", hour_out, 8'h12);
    chk("reset12.pm", {7'd0, pm_out}, 8'h00);
    mode24_in = 1'b1;
    @(posedge clk);
    #1;
    reset_in = 1'b1;
    run_in   = 1'b1;

    // counting from reset
    repeat (40) step("count");
    chk("count.sec10", sec_out, 8'h10);
    chk("count.tick40", {7'd0, tick_out}, 8'h01);
    repeat (200) step("count");
    chk("wrap.sec", sec_out, 8'h00);
    chk("wrap.min", min_out, 8'h01);

    // pause
    run_in = 1'b0;
    repeat (10) step("pause");
    chk("pause.sec", sec_out, 8'h00);
    chk("pause.min", min_out, 8'h01);

    // day rollover
    do_set(2'd2, 8'h23, "set_h");
    do_set(2'd1, 8'h59, "set_m");
    do_set(2'd0, 8'h58, "set_s");
    run_in = 1'b1;
    repeat (4) step("roll");
    chk("roll.sec59", sec_out, 8'h59);
    repeat (4) step("roll");
    chk("roll.hour", hour_out, 8'h00);
    chk("roll.min", min_out, 8'h00);
    chk("roll.sec", sec_out, 8'h00);
    chk("roll.pulse", {7'd0, rollover_out}, 8'h01);
    chk("roll.tick", {7'd0, tick_out}, 8'h01);

    // reset mid-pulse clears everything without a clock edge
    reset_in = 1'b0;
    model_reset();
    #1;
    check_all("async");
    chk("async.roll", {7'd0, rollover_out}, 8'h00);
    reset_in = 1'b1;
    run_in   = 1'b0;

    // 12-hour decode
    mode24_in = 1'b0;
    do_set(2'd2, 8'h13, "h13");
    chk("h13.hour", hour_out, 8'h01);
    chk("h13.pm", {7'd0, pm_out}, 8'h01);
    do_set(2'd2, 8'h12, "h12");
    chk("h12.hour", hour_out, 8'h12);
    chk("h12.pm", {7'd0, pm_out}, 8'h01);
    do_set(2'd2, 8'h00, "h00");
    chk("h00.hour", hour_out, 8'h12);
    chk("h00.pm", {7'd0, pm_out}, 8'h00);
    do_set(2'd2, 8'h13, "h13b");
    mode24_in = 1'b1;
    #1;
    chk("mode24.hour", hour_out, 8'h13);
    chk("mode24.pm", {7'd0, pm_out}, 8'h00);
    check_all("mode24");

    // invalid sets
    do_set(2'd0, 8'h60, "bad_sec");
    chk("bad_sec.err", {7'd0, err_out}, 8'h01);
    step("bad_sec.clr");
    do_set(2'd1, 8'h1A, "bad_min");
    chk("bad_min.err", {7'd0, err_out}, 8'h01);
    step("bad_min.clr");
    do_set(2'd2, 8'h24, "bad_hour");
    chk("bad_hour.err", {7'd0, err_out}, 8'h01);
    chk("bad_hour.hour", hour_out, 8'h13);
    step("bad_hour.clr");
    do_set(2'd3, 8'h05, "bad_sel");
    chk("bad_sel.err", {7'd0, err_out}, 8'h01);
    do_set(2'd1, 8'h42, "good_set");
    chk("good_set.err", {7'd0, err_out}, 8'h00);
    chk("good_set.min", min_out, 8'h42);

    // set colliding with a carrying tick
    do_set(2'd2, 8'h05, "col_h");
    do_set(2'd1, 8'h10, "col_m");
    do_set(2'd0, 8'h59, "col_s");
    run_in = 1'b1;
    repeat (3) step("col_wait");
    do_set(2'd1, 8'h30, "col");
    chk("col.sec", sec_out, 8'h00);
    chk("col.min", min_out, 8'h30);
    chk("col.hour", hour_out, 8'h05);
    chk("col.tick", {7'd0, tick_out}, 8'h01);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      run_in = ($urandom % 8) != 0;
      if ($urandom % 32 == 0) mode24_in = ~mode24_in;
      set_en_in  = ($urandom % 12) == 0;
      set_sel_in = 2'($urandom % 4);
      if ($urandom % 2 == 0) set_val_in = to_bcd($urandom_range(0, 59));
      else set_val_in = 8'($urandom % 256);
      step("rand");
    end
    set_en_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
